// File: rtl/banco_write_arbiter_if.sv
// Requester handshakes and register-bank write bus of the write arbiter.
// master = requester/bank side, slave = arbiter.
interface banco_write_arbiter_if;
   logic       ReqValid0;
   logic       ReqReady0;
   logic [2:0] ReqReg0;
   logic [7:0] ReqData0;
   logic       ReqValid1;
   logic       ReqReady1;
   logic [2:0] ReqReg1;
   logic [7:0] ReqData1;
   logic [2:0] WriteReg;
   logic [7:0] WriteData;
   logic       RegWrite;
   logic [7:0] Busy;

   // valid/ready: a write transfers on a rising edge where ReqValidi & ReqReadyi;
   // ReqReadyi depends only on FIFO occupancy, and the payload must stay stable
   // while valid is high and ready is low.
   modport master (
      output ReqValid0, ReqReg0, ReqData0,
      output ReqValid1, ReqReg1, ReqData1,
      input  ReqReady0, ReqReady1,
      input  WriteReg, WriteData, RegWrite, Busy
   );

   modport slave (
      input  ReqValid0, ReqReg0, ReqData0,
      input  ReqValid1, ReqReg1, ReqData1,
      output ReqReady0, ReqReady1,
      output WriteReg, WriteData, RegWrite, Busy
   );
endinterface

// File: rtl/banco_write_arbiter.sv
// Two-requester round-robin write arbiter for the 8x8 register bank.
// Optional BANCO_ZERO_REG_EN: register 0 is constant zero, writes to it are dropped.
module banco_write_arbiter #(
   parameter int DEPTH = 2
) (
   input logic                  clock,
   input logic                  reset_n,
   banco_write_arbiter_if.slave bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [2:0]    fifo_reg  [2][DEPTH];
   logic [7:0]    fifo_data [2][DEPTH];
   logic [AW-1:0] rd_ptr [2];
   logic [AW-1:0] wr_ptr [2];
   logic [CW-1:0] count  [2];

   logic [1:0] req_valid;
   logic [2:0] req_reg  [2];
   logic [7:0] req_data [2];
   logic [1:0] ready;
   logic [1:0] nonempty;
   logic [1:0] push;
   logic [1:0] pop;
   logic       any_pop;
   logic       grant;
   logic       rr_ptr;

   logic [2:0] write_reg_q;
   logic [7:0] write_data_q;
   logic       reg_write_q;
   logic [7:0] busy;

   always_comb begin
      req_valid   = {bus.ReqValid1, bus.ReqValid0};
      req_reg[0]  = bus.ReqReg0;
      req_reg[1]  = bus.ReqReg1;
      req_data[0] = bus.ReqData0;
      req_data[1] = bus.ReqData1;
   end

   // Ready looks only at the count, so a full FIFO refuses even while being popped.
   always_comb begin
      ready    = '0;
      nonempty = '0;
      push     = '0;
      for (int i = 0; i < 2; i++) begin
         ready[i]    = (count[i] != FULL_CNT);
         nonempty[i] = (count[i] != '0);
`ifdef BANCO_ZERO_REG_EN
         push[i]     = req_valid[i] & ready[i] & (req_reg[i] != 3'd0);
`else
         push[i]     = req_valid[i] & ready[i];
`endif
      end
   end

   always_comb begin
      grant = 1'b0;
      if (nonempty[0] && nonempty[1]) begin
         grant = rr_ptr;
      end else if (nonempty[1]) begin
         grant = 1'b1;
      end
      any_pop = |nonempty;
      pop[0]  = any_pop & ~grant;
      pop[1]  = any_pop & grant;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + CW'(1);
               2'b01:   count[i] <= count[i] - CW'(1);
               default: count[i] <= count[i];
            endcase
         end
      end
   end

   // Entry storage needs no reset: only slots counted as valid are ever read.
   always_ff @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) begin
            fifo_reg[i][wr_ptr[i]]  <= req_reg[i];
            fifo_data[i][wr_ptr[i]] <= req_data[i];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
         rr_ptr       <= 1'b0;
      end else if (any_pop) begin
         reg_write_q  <= 1'b1;
         write_reg_q  <= fifo_reg[grant][rd_ptr[grant]];
         write_data_q <= fifo_data[grant][rd_ptr[grant]];
         rr_ptr       <= ~grant;
      end else begin
         reg_write_q  <= 1'b0;
      end
   end

   // Busy covers every occupied FIFO slot plus the write currently on the bank port.
   always_comb begin
      busy = '0;
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count[i]) begin
               busy[fifo_reg[i][rd_ptr[i] + AW'(k)]] = 1'b1;
            end
         end
      end
      if (reg_write_q) busy[write_reg_q] = 1'b1;
`ifdef BANCO_ZERO_REG_EN
      busy[0] = 1'b0;
`endif
   end

   assign bus.ReqReady0 = ready[0];
   assign bus.ReqReady1 = ready[1];
   assign bus.WriteReg  = write_reg_q;
   assign bus.WriteData = write_data_q;
   assign bus.RegWrite  = reg_write_q;
   assign bus.Busy      = busy;

endmodule

// File: tb/tb_banco_write_arbiter.sv
// Bench for banco_write_arbiter: directed scenarios plus random traffic against
// a queue-based transaction model of the two FIFOs and the round-robin grant.
module tb_banco_write_arbiter;

   localparam int DEPTH = 2;
`ifdef BANCO_ZERO_REG_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif

   logic clock;
   logic reset_n;
   banco_write_arbiter_if bus();

   banco_write_arbiter #(.DEPTH(DEPTH)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // ---------------- clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // ---------------- scoreboard state
   int n_cmp = 0;
   int n_err = 0;

   logic [10:0] exp_q0[$];
   logic [10:0] exp_q1[$];
   logic        exp_rr;
   logic        exp_rw;
   logic [2:0]  exp_wr;
   logic [7:0]  exp_wd;

   logic [10:0] wr_log[$];
   logic [10:0] exp_log[$];
   logic [10:0] src0[$];
   logic [10:0] src1[$];

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_busy();
      logic [7:0] b;
      b = '0;
      foreach (exp_q0[k]) b[exp_q0[k][10:8]] = 1'b1;
      foreach (exp_q1[k]) b[exp_q1[k][10:8]] = 1'b1;
      if (exp_rw) b[exp_wr] = 1'b1;
      if (ZERO_EN) b[0] = 1'b0;
      return b;
   endfunction

   task automatic model_clear();
      exp_q0.delete();
      exp_q1.delete();
      exp_rr = 1'b0;
      exp_rw = 1'b0;
      exp_wr = '0;
      exp_wd = '0;
   endtask

   // Advance the model across one rising edge given the inputs presented to it.
   task automatic model_step(input logic v0, input logic [2:0] r0, input logic [7:0] d0,
                             input logic v1, input logic [2:0] r1, input logic [7:0] d1);
      logic acc0, acc1, have, g;
      logic [10:0] e;
      acc0 = v0 && (exp_q0.size() < DEPTH);
      acc1 = v1 && (exp_q1.size() < DEPTH);
      have = 1'b1;
      g    = 1'b0;
      if (exp_q0.size() > 0 && exp_q1.size() > 0) g = exp_rr;
      else if (exp_q0.size() > 0) g = 1'b0;
      else if (exp_q1.size() > 0) g = 1'b1;
      else have = 1'b0;
      if (have) begin
         e      = g ? exp_q1.pop_front() : exp_q0.pop_front();
         exp_rw = 1'b1;
         exp_wr = e[10:8];
         exp_wd = e[7:0];
         exp_rr = ~g;
      end else begin
         exp_rw = 1'b0;
      end
      if (acc0 && !(ZERO_EN && r0 == 3'd0)) exp_q0.push_back({r0, d0});
      if (acc1 && !(ZERO_EN && r1 == 3'd0)) exp_q1.push_back({r1, d1});
   endtask

   task automatic check_all();
      check_val("ready0", bus.ReqReady0, (exp_q0.size() < DEPTH));
      check_val("ready1", bus.ReqReady1, (exp_q1.size() < DEPTH));
      check_val("regwrite", bus.RegWrite, exp_rw);
      check_val("writereg", bus.WriteReg, exp_wr);
      check_val("writedata", bus.WriteData, exp_wd);
      check_val("busy", bus.Busy, model_busy());
      if (bus.RegWrite) wr_log.push_back({bus.WriteReg, bus.WriteData});
   endtask

   // ---------------- driver tasks (called just after a falling edge)
   task automatic step(input logic v0, input logic [2:0] r0, input logic [7:0] d0,
                       input logic v1, input logic [2:0] r1, input logic [7:0] d1);
      bus.ReqValid0 = v0;
      bus.ReqReg0   = r0;
      bus.ReqData0  = d0;
      bus.ReqValid1 = v1;
      bus.ReqReg1   = r1;
      bus.ReqData1  = d1;
      model_step(v0, r0, d0, v1, r1, d1);
      @(posedge clock);
      @(negedge clock);
      check_all();
   endtask

   task automatic idle_inputs();
      bus.ReqValid0 = 1'b0;
      bus.ReqReg0   = '0;
      bus.ReqData0  = '0;
      bus.ReqValid1 = 1'b0;
      bus.ReqReg1   = '0;
      bus.ReqData1  = '0;
   endtask

   task automatic reset_pulse();
      #2;
      idle_inputs();
      reset_n = 1'b0;
      #1;
      check_val("rst_regwrite", bus.RegWrite, 1'b0);
      check_val("rst_busy", bus.Busy, 8'h00);
      check_val("rst_ready0", bus.ReqReady0, 1'b1);
      check_val("rst_ready1", bus.ReqReady1, 1'b1);
      check_val("rst_writereg", bus.WriteReg, 3'd0);
      check_val("rst_writedata", bus.WriteData, 8'h00);
      model_clear();
      @(posedge clock);
      @(negedge clock);
      #2;
      reset_n = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check_all();
   endtask

   // Requesters hold each offer until accepted, then the bench drains the FIFOs.
   task automatic run_srcs(input string tag);
      int cyc;
      logic v0, v1, a0, a1;
      logic [10:0] p0, p1;
      cyc = 0;
      while ((src0.size() > 0 || src1.size() > 0 || exp_q0.size() > 0 ||
              exp_q1.size() > 0 || exp_rw) && cyc < 60) begin
         v0 = (src0.size() > 0);
         v1 = (src1.size() > 0);
         p0 = v0 ? src0[0] : 11'd0;
         p1 = v1 ? src1[0] : 11'd0;
         a0 = v0 && bus.ReqReady0;
         a1 = v1 && bus.ReqReady1;
         step(v0, p0[10:8], p0[7:0], v1, p1[10:8], p1[7:0]);
         if (a0) void'(src0.pop_front());
         if (a1) void'(src1.pop_front());
         cyc++;
      end
      check_val({tag, "_drained"},
                (src0.size() == 0 && src1.size() == 0 && exp_q0.size() == 0 &&
                 exp_q1.size() == 0 && !exp_rw), 1'b1);
   endtask

   task automatic compare_log(input string tag);
      check_val({tag, "_count"}, 16'(wr_log.size()), 16'(exp_log.size()));
      for (int i = 0; i < wr_log.size() && i < exp_log.size(); i++) begin
         check_val(tag, wr_log[i], exp_log[i]);
      end
      wr_log.delete();
      exp_log.delete();
   endtask

   // ---------------- stimulus
   initial begin
      reset_n = 1'b0;
      idle_inputs();
      model_clear();
      @(negedge clock);
      check_val("init_regwrite", bus.RegWrite, 1'b0);
      check_val("init_busy", bus.Busy, 8'h00);
      #2;
      reset_n = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check_all();

      // single write after a mid-cycle reset pulse
      reset_pulse();
      wr_log.delete();
      src0.push_back({3'd3, 8'hA5});
      run_srcs("single");
      exp_log.push_back({3'd3, 8'hA5});
      compare_log("single_log");

      // back-to-back pushes from requester 1 only
      for (int r = 1; r <= 5; r++) src1.push_back({3'(r), 8'(8'h10 + r)});
      run_srcs("stream1");
      for (int r = 1; r <= 5; r++) exp_log.push_back({3'(r), 8'(8'h10 + r)});
      compare_log("stream1_log");

      // contention: both requesters, alternating grants
      reset_pulse();
      wr_log.delete();
      src0.push_back({3'd1, 8'h01});
      src0.push_back({3'd2, 8'h02});
      src0.push_back({3'd3, 8'h03});
      src1.push_back({3'd5, 8'h05});
      src1.push_back({3'd6, 8'h06});
      src1.push_back({3'd7, 8'h07});
      run_srcs("contend");
      exp_log.push_back({3'd1, 8'h01});
      exp_log.push_back({3'd5, 8'h05});
      exp_log.push_back({3'd2, 8'h02});
      exp_log.push_back({3'd6, 8'h06});
      exp_log.push_back({3'd3, 8'h03});
      exp_log.push_back({3'd7, 8'h07});
      compare_log("contend_log");

      // FIFO0 fills while requester 1 holds the grant
      src1.push_back({3'd4, 8'h40});
      src1.push_back({3'd5, 8'h50});
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h40);
      void'(src1.pop_front());
      for (int k = 0; k < 4; k++) src0.push_back({3'(k), 8'(8'hC0 + k)});
      run_srcs("fill0");
      check_val("fill0_total", 16'(wr_log.size()), 16'd6);
      wr_log.delete();

      // reset with writes queued and in flight
      step(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
      step(1'b1, 3'd3, 8'h33, 1'b1, 3'd4, 8'h44);
      reset_pulse();
      wr_log.delete();
      for (int k = 0; k < 4; k++) step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
      compare_log("post_reset_log");

      // register 0 handling
      src0.push_back({3'd0, 8'hFF});
      src0.push_back({3'd4, 8'h11});
      run_srcs("zero");
      if (!ZERO_EN) exp_log.push_back({3'd0, 8'hFF});
      exp_log.push_back({3'd4, 8'h11});
      compare_log("zero_log");

      // random traffic
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 149) == 0) begin
            reset_pulse();
         end else begin
            step($urandom_range(0, 99) < 60, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < 50, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
         end
      end
      for (int c = 0; c < 6; c++) step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
